// File: rtl/dsi_arb_pkg.sv
// Shared types and constants for the DSI lane packet arbiter.
package dsi_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_DRAIN, ARB_XFER, ARB_GAP} arb_state_t;

    localparam int   ARB_MAX_SRC   = 8;
    localparam int   ARB_CNT_W_DEF = 16;
    localparam logic MODE_LP       = 1'b1;
    localparam logic MODE_HS       = 1'b0;

endpackage

// File: rtl/dsi_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module dsi_rr_pick
    import dsi_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
)
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    localparam int unsigned NU = N;

    int unsigned cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 1; k <= ARB_MAX_SRC; k++) begin
            if (k <= NU) begin
                cand = 32'(ptr) + k;
                if (cand >= NU) cand = cand - NU;
                for (int unsigned i = 0; i < NU; i++) begin
                    if (!found && cand == i && req[i]) begin
                        found     = 1'b1;
                        onehot[i] = 1'b1;
                        idx       = IDX_W'(i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dsi_lane_packet_arbiter.sv
// Packet-atomic round-robin arbiter in front of the lane byte FIFO, with gap, drain and stall watchdog.
// Optional DSI_ARB_STATS_EN adds per-source packet counters and a stall event counter.
module dsi_lane_packet_arbiter
    import dsi_arb_pkg::*;
#(
    parameter int N_SRC = 2,
    parameter int CNT_W = ARB_CNT_W_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [CNT_W-1:0]   gap_cycles,
    input  logic [CNT_W-1:0]   stall_limit,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [8*N_SRC-1:0] src_data,
    input  logic [N_SRC-1:0]   src_last,
    input  logic [N_SRC-1:0]   src_lp,
    output logic [N_SRC-1:0]   src_ready,
    output logic [7:0]         fifo_wdata,
    output logic               fifo_lp,
    output logic               fifo_write,
    input  logic               fifo_full,
    input  logic               lane_busy,
    output logic [N_SRC-1:0]   grant,
    output logic               busy,
    output logic               err_stall
`ifdef DSI_ARB_STATS_EN
    ,
    output logic [16*N_SRC-1:0] pkt_count,
    output logic [15:0]         stall_count
`endif
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    arb_state_t       state, state_nxt;
    logic [N_SRC-1:0] grant_q;
    logic [IDX_W-1:0] gidx_q, rr_ptr;
    logic             pkt_lp, last_mode, last_mode_valid;
    logic [CNT_W-1:0] gap_cnt, stall_cnt;

    logic [N_SRC-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             sel_lp, g_valid, g_last, wr, pkt_done;
    logic [7:0]       g_data;

    dsi_rr_pick #(.N(N_SRC), .IDX_W(IDX_W)) u_pick (
        .req    (src_valid),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        g_data = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) g_data = g_data | src_data[8*i +: 8];
        end
    end

    assign sel_lp   = |(src_lp & pick_oh);
    assign g_valid  = |(src_valid & grant_q);
    assign g_last   = |(src_last & grant_q);
    assign wr       = (state == ARB_XFER) && g_valid && !fifo_full;
    assign pkt_done = wr && g_last;
    assign grant    = grant_q;
    assign busy     = (state != ARB_IDLE);

    always_comb begin
        state_nxt  = state;
        src_ready  = '0;
        fifo_write = 1'b0;
        fifo_wdata = '0;
        fifo_lp    = 1'b0;
        err_stall  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (enable && pick_found) begin
                    // A mode switch must wait for the bridge to finish its burst.
                    if (last_mode_valid && (sel_lp != last_mode) && lane_busy) state_nxt = ARB_DRAIN;
                    else                                                     state_nxt = ARB_XFER;
                end
            end
            ARB_DRAIN: begin
                if (!lane_busy) state_nxt = ARB_XFER;
            end
            ARB_XFER: begin
                src_ready  = fifo_full ? '0 : grant_q;
                fifo_write = wr;
                fifo_wdata = g_data;
                fifo_lp    = (pkt_lp == MODE_LP);
                err_stall  = !wr && (stall_limit != '0) && (stall_cnt == stall_limit - CNT_W'(1));
                if (pkt_done) state_nxt = (gap_cycles == '0) ? ARB_IDLE : ARB_GAP;
            end
            ARB_GAP: begin
                if (gap_cnt <= CNT_W'(1)) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ARB_IDLE;
            grant_q         <= '0;
            gidx_q          <= '0;
            rr_ptr          <= IDX_W'(N_SRC - 1);
            pkt_lp          <= MODE_HS;
            last_mode       <= MODE_HS;
            last_mode_valid <= 1'b0;
            gap_cnt         <= '0;
            stall_cnt       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ARB_IDLE: begin
                    if (state_nxt != ARB_IDLE) begin
                        grant_q <= pick_oh;
                        gidx_q  <= pick_idx;
                        pkt_lp  <= sel_lp;
                    end
                end
                ARB_XFER: begin
                    if (wr)                 stall_cnt <= '0;
                    else if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
                    if (pkt_done) begin
                        grant_q         <= '0;
                        rr_ptr          <= gidx_q;
                        last_mode       <= pkt_lp;
                        last_mode_valid <= 1'b1;
                        gap_cnt         <= gap_cycles;
                        stall_cnt       <= '0;
                    end
                end
                ARB_GAP: gap_cnt <= gap_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef DSI_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (pkt_done && grant_q[i]) pkt_count[16*i +: 16] <= pkt_count[16*i +: 16] + 16'd1;
            end
            if (err_stall && stall_count != '1) stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dsi_lane_packet_arbiter.sv
// Scoreboard bench for dsi_lane_packet_arbiter; builds with or without DSI_ARB_STATS_EN.
module tb_dsi_lane_packet_arbiter;
    import dsi_arb_pkg::*;

    localparam int N  = 2;
    localparam int CW = 16;

    typedef struct packed { logic [7:0] d; logic last; logic lp; } sb_t;
    typedef struct packed { logic [3:0] src; logic [7:0] d; logic lp; } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b1;
    logic [CW-1:0]   gap_cycles = '0;
    logic [CW-1:0]   stall_limit = '0;
    logic [N-1:0]    src_valid = '0;
    logic [8*N-1:0]  src_data = '0;
    logic [N-1:0]    src_last = '0;
    logic [N-1:0]    src_lp = '0;
    logic [N-1:0]    src_ready;
    logic [7:0]      fifo_wdata;
    logic            fifo_lp;
    logic            fifo_write;
    logic            fifo_full = 1'b0;
    logic            lane_busy = 1'b0;
    logic [N-1:0]    grant;
    logic            busy;
    logic            err_stall;
`ifdef DSI_ARB_STATS_EN
    logic [16*N-1:0] pkt_count;
    logic [15:0]     stall_count;
`endif

    sb_t          sq[N][$];
    exp_t         exp_q[$];
    logic [N-1:0] hold = '0;
    logic [N-1:0] acc = '0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    dsi_lane_packet_arbiter #(.N_SRC(N), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .gap_cycles  (gap_cycles),
        .stall_limit (stall_limit),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_last    (src_last),
        .src_lp      (src_lp),
        .src_ready   (src_ready),
        .fifo_wdata  (fifo_wdata),
        .fifo_lp     (fifo_lp),
        .fifo_write  (fifo_write),
        .fifo_full   (fifo_full),
        .lane_busy   (lane_busy),
        .grant       (grant),
        .busy        (busy),
        .err_stall   (err_stall)
`ifdef DSI_ARB_STATS_EN
        ,
        .pkt_count   (pkt_count),
        .stall_count (stall_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            if (sq[i].size() > 0) begin
                src_valid[i]       = !hold[i];
                src_data[8*i +: 8] = sq[i][0].d;
                src_last[i]        = sq[i][0].last;
                src_lp[i]          = sq[i][0].lp;
            end else begin
                src_valid[i]       = 1'b0;
                src_data[8*i +: 8] = '0;
                src_last[i]        = 1'b0;
                src_lp[i]          = 1'b0;
            end
        end
    endtask

    // Negedge: scoreboard compare on every write, note accepted bytes.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        acc = src_valid & src_ready;
        if (!rst) begin
            check("ready_outside_grant", 32'(src_ready & ~grant), 32'd0);
            if (fifo_write) begin
                check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_data", 32'(fifo_wdata), 32'(e.d));
                    check("wr_lp", 32'(fifo_lp), 32'(e.lp));
                    check("wr_grant", 32'(grant), 32'd1 << e.src);
                end
            end
        end
    endtask

    // Posedge+1: retire accepted bytes and present the next ones.
    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        end
        drive_srcs();
    endtask

    task automatic push_pkt(input int s, input int len, input logic lp, input logic [7:0] base);
        sb_t  b;
        exp_t e;
        for (int k = 0; k < len; k++) begin
            b.d    = base + 8'(k);
            b.last = (k == len - 1);
            b.lp   = lp;
            sq[s].push_back(b);
            e.src = 4'(s);
            e.d   = b.d;
            e.lp  = lp;
            exp_q.push_back(e);
        end
        drive_srcs();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        enable      = 1'b1;
        gap_cycles  = '0;
        stall_limit = '0;
        fifo_full   = 1'b0;
        lane_busy   = 1'b0;
        hold        = '0;
        for (int i = 0; i < N; i++) sq[i].delete();
        exp_q.delete();
        drive_srcs();
        sample(); advance();
        sample(); advance();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_src_ready", 32'(src_ready), 32'd0);
        check("rst_fifo_write", 32'(fifo_write), 32'd0);
        check("rst_fifo_wdata", 32'(fifo_wdata), 32'd0);
        check("rst_fifo_lp", 32'(fifo_lp), 32'd0);
        check("rst_err_stall", 32'(err_stall), 32'd0);
`ifdef DSI_ARB_STATS_EN
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_stall_count", 32'(stall_count), 32'd0);
`endif
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((sq[0].size() > 0 || sq[1].size() > 0 || busy) && n < budget) begin
            sample();
            advance();
            n++;
        end
        check("done_in_budget", 32'(n < budget), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   n;
        logic hit;

        // 1: single HS packet with a 3-cycle gap
        do_reset();
        sample(); check_reset_outputs(); advance();
        gap_cycles = 16'd3;
        push_pkt(0, 4, MODE_HS, 8'h10);
        sample();
        check("t1_grant_c0", 32'(grant), 32'd0);
        advance();
        for (int k = 0; k < 4; k++) begin
            sample();
            check("t1_grant_xfer", 32'(grant), 32'd1);
            check("t1_write_b2b", 32'(fifo_write), 32'd1);
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            sample();
            check("t1_gap_busy", 32'(busy), 32'd1);
            check("t1_gap_grant", 32'(grant), 32'd0);
            check("t1_gap_nowrite", 32'(fifo_write), 32'd0);
            advance();
        end
        sample();
        check("t1_idle_after_gap", 32'(busy), 32'd0);
        advance();

        // 2: both sources busy, gap 0 -> strict alternation of whole packets
        do_reset();
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, 2, MODE_HS, 8'h20 + 8'(16 * p));
            push_pkt(1, 2, MODE_HS, 8'h80 + 8'(16 * p));
        end
        wait_done(60);
`ifdef DSI_ARB_STATS_EN
        check("t2_pkt_count", 32'(pkt_count), 32'h0003_0003);
`endif

        // 3: HS then LP while the bridge is busy -> drain until lane_busy falls
        do_reset();
        lane_busy = 1'b1;
        push_pkt(0, 2, MODE_HS, 8'h30);
        push_pkt(1, 2, MODE_LP, 8'h40);
        n = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            sample();
            hit = (grant == 2'b10);
            if (!hit) advance();
            n++;
        end
        check("t3_drain_seen", 32'(hit), 32'd1);
        check("t3_drain_nowrite", 32'(fifo_write), 32'd0);
        check("t3_drain_ready", 32'(src_ready), 32'd0);
        for (int k = 2; k <= 10; k++) begin
            advance();
            sample();
            check("t3_drain_hold_grant", 32'(grant), 32'd2);
            check("t3_drain_hold_nowrite", 32'(fifo_write), 32'd0);
        end
        advance();
        lane_busy = 1'b0;
        sample();
        check("t3_drain_last", 32'(fifo_write), 32'd0);
        advance();
        sample();
        check("t3_first_lp_write", 32'(fifo_write), 32'd1);
        advance();
        wait_done(20);

        // 4: stall watchdog fires once on the 5th idle cycle
        do_reset();
        stall_limit = 16'd5;
        push_pkt(0, 6, MODE_HS, 8'h50);
        sample(); advance();
        sample(); check("t4_w0", 32'(fifo_write), 32'd1); advance();
        sample(); check("t4_w1", 32'(fifo_write), 32'd1); advance();
        hold[0] = 1'b1;
        drive_srcs();
        for (int k = 1; k <= 8; k++) begin
            sample();
            check("t4_err_stall", 32'(err_stall), 32'(k == 5));
            check("t4_stall_grant", 32'(grant), 32'd1);
            advance();
        end
        hold[0] = 1'b0;
        drive_srcs();
        wait_done(20);
`ifdef DSI_ARB_STATS_EN
        check("t4_stall_count", 32'(stall_count), 32'd1);
`endif

        // 5: fifo_full mid-packet, watchdog off
        do_reset();
        push_pkt(0, 8, MODE_LP, 8'h60);
        sample(); advance();
        for (int k = 0; k < 3; k++) begin
            sample(); check("t5_pre_write", 32'(fifo_write), 32'd1); advance();
        end
        fifo_full = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample();
            check("t5_full_ready", 32'(src_ready), 32'd0);
            check("t5_full_nowrite", 32'(fifo_write), 32'd0);
            check("t5_full_no_err", 32'(err_stall), 32'd0);
            advance();
        end
        fifo_full = 1'b0;
        wait_done(20);

        // 6: single-byte packet, then reset in the middle of the next one
        do_reset();
        push_pkt(0, 1, MODE_HS, 8'h70);
        wait_done(10);
        push_pkt(0, 6, MODE_HS, 8'h71);
        sample(); advance();
        sample(); advance();
        sample(); advance();
        rst = 1'b1;
        for (int i = 0; i < N; i++) sq[i].delete();
        exp_q.delete();
        drive_srcs();
        sample(); advance();
        sample();
        check_reset_outputs();
        advance();
        rst = 1'b0;

        // 7: enable low blocks grants; dropping it mid-packet still completes it
        do_reset();
        enable = 1'b0;
        push_pkt(1, 3, MODE_LP, 8'hA0);
        for (int k = 0; k < 5; k++) begin
            sample();
            check("t7_disabled_busy", 32'(busy), 32'd0);
            check("t7_disabled_grant", 32'(grant), 32'd0);
            advance();
        end
        enable = 1'b1;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            sample();
            hit = fifo_write;
            advance();
            n++;
        end
        check("t7_first_write", 32'(hit), 32'd1);
        enable = 1'b0;
        wait_done(20);
        enable = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
